pixel_write_coalescer: RTL and testbench

Parametrised successor to the framebuffer write-request path. Accepts one pixel per cycle from the rasterizer (hcount/vcount/color), coalesces pixels that fall in the same DRAM word into one MIG write word with byte strobes, and emits word writes to the out FIFO feeding the MIG. Generalised over pixel width, word width and frame count. Flushes partial words on a non-sequential address, a completed word, an idle timeout or an explicit flush. Has a registered output stage with a proper valid/ready handshake.

---
 rtl/fb_pkg.sv | 52 +++++
 rtl/fb_req_skid.sv | 35 +++
 rtl/pixel_write_coalescer.sv | 173 +++++++++++++++++
 tb/tb_pixel_write_coalescer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer types and address helpers for the MIG
// request paths (write coalescer and read request).
package fb_pkg;

  typedef enum logic [0:0] {
    EMPTY,
    ACCUM
  } acc_state_t;

  localparam int MIG_AW = 27;
  localparam int MIG_DW = 128;
  localparam int MIG_SW = MIG_DW / 8;

  typedef struct packed {
    logic [MIG_AW-1:0] addr;
    logic [MIG_DW-1:0] data;
    logic [MIG_SW-1:0] strobe;
  } mig_wr_req_t;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] slot;
  } pix_loc_t;

  function automatic int frame_words(
    input int hres,
    input int vres,
    input int ppw
  );
    return (hres * vres + ppw - 1) / ppw;
  endfunction

  // Full-width pixel index; no truncation before the shift.
  function automatic pix_loc_t pix_to_word(
    input int h,
    input int v,
    input int f,
    input int hres,
    input int fwords,
    input int ppw_log2
  );
    int       pix;
    int       wi;
    pix_loc_t loc;
    pix      = h + hres * v;
    wi       = pix >> ppw_log2;
    loc.word = f * fwords + wi;
    loc.slot = pix - (wi << ppw_log2);
    return loc;
  endfunction

endpackage

// File: rtl/fb_req_skid.sv
// Registered request stage with a valid/ready handshake;
// shared by the framebuffer read and write request paths.
module fb_req_skid #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_rdy,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_free
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign o_free  = !r_valid || i_rdy;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_rdy) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_write_coalescer.sv
// Merges rasterizer pixels into strobed MIG word writes and
// flushes partial words on address break, timeout or flush.
module pixel_write_coalescer
  import fb_pkg::*;
#(
  parameter int HRES          = 320,
  parameter int VRES          = 180,
  parameter int PIXEL_WIDTH   = 16,
  parameter int WORD_WIDTH    = 128,
  parameter int NUM_FRAMES    = 2,
  parameter int ADDR_WIDTH    = 27,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [$clog2(HRES)-1:0] hcount_in,
  input  logic [$clog2(VRES)-1:0] vcount_in,
  input  logic [PIXEL_WIDTH-1:0]  color_in,
  input  logic [((NUM_FRAMES>1) ?
    $clog2(NUM_FRAMES) : 1)-1:0]  frame_in,
  input  logic                    mask_in,
  input  logic                    valid_in,
  output logic                    rdy_out,
  input  logic                    flush_in,
  output logic [ADDR_WIDTH-1:0]   addr_out,
  output logic [WORD_WIDTH-1:0]   data_out,
  output logic [WORD_WIDTH/8-1:0] strobe_out,
  output logic                    valid_out,
  input  logic                    rdy_in,
  output logic                    busy_out
);

  localparam int PPW = WORD_WIDTH / PIXEL_WIDTH;
  localparam int BPP = PIXEL_WIDTH / 8;
  localparam int SW = WORD_WIDTH / 8;
  localparam int PPW_LOG = $clog2(PPW);
  localparam int FRAME_WORDS = frame_words(HRES, VRES, PPW);
  localparam int TW = (FLUSH_TIMEOUT > 0) ?
    $clog2(FLUSH_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO = TW'(FLUSH_TIMEOUT);
  localparam int RW = ADDR_WIDTH + WORD_WIDTH + SW;

  acc_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_acc_word;
  logic [WORD_WIDTH-1:0] r_acc_data;
  logic [SW-1:0]         r_acc_strb;
  logic [TW-1:0]         r_tcnt;
  logic                  r_pend;

  pix_loc_t              w_loc;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_same;
  logic [WORD_WIDTH-1:0] w_mdata;
  logic [SW-1:0]         w_mstrb;
  logic                  w_full;
  logic                  w_free;
  logic                  w_acc;
  logic                  w_px;
  logic                  w_diff;
  logic                  w_fl;
  logic                  w_tmo;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] w_ld_word;
  logic [WORD_WIDTH-1:0] w_ld_data;
  logic [SW-1:0]         w_ld_strb;
  logic [RW-1:0]         w_out;

  assign w_loc = pix_to_word(int'(hcount_in),
    int'(vcount_in), int'(frame_in), HRES,
    FRAME_WORDS, PPW_LOG);
  assign w_word = w_loc.word[ADDR_WIDTH-1:0];
  assign w_same = (r_state == ACCUM) &&
    (w_word == r_acc_word);

  always_comb begin
    w_mdata = w_same ? r_acc_data : '0;
    w_mstrb = w_same ? r_acc_strb : '0;
    for (int k = 0; k < PPW; k++) begin
      if (w_loc.slot == 32'(k)) begin
        w_mdata[k*PIXEL_WIDTH +: PIXEL_WIDTH] = color_in;
        w_mstrb[k*BPP +: BPP] = '1;
      end
    end
  end

  assign w_full = &w_mstrb;

  // A fresh or same-word merge only needs the output
  // register when it completes the word.
  assign rdy_out = w_free || mask_in ||
    (valid_in && !w_full &&
     (w_same || (r_state == EMPTY)));

  assign w_acc  = valid_in && rdy_out;
  assign w_px   = w_acc && !mask_in;
  assign w_diff = w_px && (r_state == ACCUM) && !w_same;
  assign w_fl   = r_pend || flush_in;
  assign w_tmo  = (FLUSH_TIMEOUT != 0) && (r_tcnt == TMO);

  always_comb begin
    w_load    = 1'b0;
    w_ld_word = r_acc_word;
    w_ld_data = r_acc_data;
    w_ld_strb = r_acc_strb;
    if (w_diff) begin
      w_load = 1'b1;
    end else if (w_px && w_full) begin
      w_load    = 1'b1;
      w_ld_word = w_word;
      w_ld_data = w_mdata;
      w_ld_strb = w_mstrb;
    end else if (r_state == ACCUM && w_free &&
                 (w_fl || w_tmo)) begin
      w_load = 1'b1;
      if (w_px) begin
        w_ld_data = w_mdata;
        w_ld_strb = w_mstrb;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state    <= EMPTY;
      r_acc_word <= '0;
      r_acc_data <= '0;
      r_acc_strb <= '0;
      r_tcnt     <= '0;
      r_pend     <= 1'b0;
    end else if (w_diff) begin
      r_acc_word <= w_word;
      r_acc_data <= w_mdata;
      r_acc_strb <= w_mstrb;
      r_tcnt     <= '0;
      r_pend     <= r_pend || flush_in;
    end else if (w_load) begin
      r_state    <= EMPTY;
      r_acc_strb <= '0;
      r_tcnt     <= '0;
      r_pend     <= 1'b0;
    end else begin
      if (w_px) begin
        r_state    <= ACCUM;
        r_acc_word <= w_word;
        r_acc_data <= w_mdata;
        r_acc_strb <= w_mstrb;
      end
      r_pend <= (r_state == ACCUM) && w_fl;
      if (w_acc) begin
        r_tcnt <= '0;
      end else if (r_state == ACCUM && r_tcnt != TMO) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  fb_req_skid #(
    .W(RW)
  ) u_skid (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .i_load  (w_load),
    .i_data  ({w_ld_word, w_ld_data, w_ld_strb}),
    .i_rdy   (rdy_in),
    .o_valid (valid_out),
    .o_data  (w_out),
    .o_free  (w_free)
  );

  assign {addr_out, data_out, strobe_out} = w_out;
  assign busy_out = (r_state == ACCUM) || valid_out;

endmodule

// File: tb/tb_pixel_write_coalescer.sv
// Directed bench for pixel_write_coalescer with a
// transaction-level coalescing model and literal pins.
module tb_pixel_write_coalescer;

  logic         clk;
  logic         rst_n;
  logic [8:0]   hcount;
  logic [7:0]   vcount;
  logic [15:0]  color;
  logic [0:0]   frame;
  logic         mask;
  logic         valid_in;
  logic         rdy_out;
  logic         flush;
  logic [26:0]  addr_out;
  logic [127:0] data_out;
  logic [15:0]  strobe_out;
  logic         valid_out;
  logic         rdy_in;
  logic         busy_out;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    int           addr;
    logic [127:0] data;
    logic [15:0]  strb;
  } wr_t;

  wr_t          q[$];
  bit           m_has;
  int           m_word;
  logic [127:0] m_data;
  logic [15:0]  m_strb;
  int           m_idle;

  pixel_write_coalescer dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .hcount_in (hcount),
    .vcount_in (vcount),
    .color_in  (color),
    .frame_in  (frame),
    .mask_in   (mask),
    .valid_in  (valid_in),
    .rdy_out   (rdy_out),
    .flush_in  (flush),
    .addr_out  (addr_out),
    .data_out  (data_out),
    .strobe_out(strobe_out),
    .valid_out (valid_out),
    .rdy_in    (rdy_in),
    .busy_out  (busy_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic void mpush();
    q.push_back('{addr: m_word, data: m_data,
                  strb: m_strb});
    m_has  = 1'b0;
    m_idle = 0;
  endfunction

  // Model: a word is one partial buffer keyed by address;
  // it leaves on address change, full strobe, flush, idle.
  initial begin : model
    int pix, w, s;
    m_has = 1'b0;
    m_idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        m_has  = 1'b0;
        m_idle = 0;
      end else begin
        if (valid_out) begin
          if (q.size() == 0) begin
            check("spurious_write", 128'(valid_out), 0);
          end else begin
            check("wr_addr", 128'(addr_out), 128'(q[0].addr));
            check("wr_data", data_out, q[0].data);
            check("wr_strobe", 128'(strobe_out),
                  128'(q[0].strb));
            if (rdy_in) void'(q.pop_front());
          end
        end
        if (valid_in && rdy_out) begin
          m_idle = 0;
          if (!mask) begin
            pix = int'(hcount) + 320 * int'(vcount);
            w = int'(frame) * 7200 + pix / 8;
            s = pix % 8;
            if (m_has && w != m_word) mpush();
            if (!m_has) begin
              m_has  = 1'b1;
              m_word = w;
              m_data = '0;
              m_strb = '0;
            end
            m_data[s*16 +: 16] = color;
            m_strb[s*2 +: 2] = 2'b11;
            if (m_strb == 16'hFFFF) mpush();
          end
        end else if (m_has) begin
          m_idle++;
          if (m_idle >= 16) mpush();
        end
        if (flush && m_has) mpush();
      end
    end
  end

  task automatic px(input int x, input int y,
                    input int f, input logic [15:0] c,
                    input logic m);
    bit got;
    got = 1'b0;
    hcount = 9'(x);
    vcount = 8'(y);
    frame = 1'(f);
    color = c;
    mask = m;
    valid_in = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      got = rdy_out;
      @(posedge clk);
      #1;
    end
    valid_in = 1'b0;
    mask = 1'b0;
    check("px_accept", 128'(got), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    for (int n = 0; n < 100 && !valid_out; n++) begin
      @(posedge clk);
      #1;
    end
    check(nm, 128'(valid_out), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin : main
    rst_n = 1'b0;
    hcount = '0;
    vcount = '0;
    color = '0;
    frame = '0;
    mask = 1'b0;
    valid_in = 1'b0;
    flush = 1'b0;
    rdy_in = 1'b1;
    idle(3);
    check("rst_valid", 128'(valid_out), 0);
    check("rst_addr", 128'(addr_out), 0);
    check("rst_data", data_out, 0);
    check("rst_strobe", 128'(strobe_out), 0);
    check("rst_busy", 128'(busy_out), 0);
    check("rst_rdy", 128'(rdy_out), 1);
    rst_n = 1'b1;
    idle(1);

    // full sequential word
    for (int x = 0; x < 7; x++)
      px(x, 0, 0, 16'h1000 + 16'(x), 1'b0);
    check("t1_not_yet", 128'(valid_out), 0);
    px(7, 0, 0, 16'h1007, 1'b0);
    check("t1_latency", 128'(valid_out), 1);
    check("t1_addr", 128'(addr_out), 0);
    check("t1_strobe", 128'(strobe_out), 128'hFFFF);
    check("t1_data", data_out,
          128'h1007_1006_1005_1004_1003_1002_1001_1000);
    idle(3);
    check("t1_idle_busy", 128'(busy_out), 0);

    // address break then idle timeout
    px(3, 0, 0, 16'h2003, 1'b0);
    px(4, 0, 0, 16'h2004, 1'b0);
    px(20, 0, 0, 16'h2020, 1'b0);
    check("t2_brk_valid", 128'(valid_out), 1);
    check("t2_brk_addr", 128'(addr_out), 0);
    check("t2_brk_strobe", 128'(strobe_out), 128'h03C0);
    idle(1);
    wait_out("t2_tmo_seen");
    check("t2_tmo_addr", 128'(addr_out), 2);
    check("t2_tmo_strobe", 128'(strobe_out), 128'h0300);
    check("t2_tmo_slot4", 128'(data_out[64 +: 16]),
          128'h2020);
    idle(3);

    // back-pressure across three full words
    rdy_in = 1'b0;
    for (int x = 0; x < 15; x++)
      px(x, 3, 0, 16'h3000 + 16'(x), 1'b0);
    hcount = 9'd15;
    vcount = 8'd3;
    frame = 1'b0;
    color = 16'h300F;
    valid_in = 1'b1;
    #1;
    check("t3_rdy_low", 128'(rdy_out), 0);
    check("t3_hold_addr", 128'(addr_out), 120);
    idle(3);
    check("t3_still_rdy_low", 128'(rdy_out), 0);
    check("t3_hold_valid", 128'(valid_out), 1);
    check("t3_hold_addr2", 128'(addr_out), 120);
    check("t3_hold_strobe", 128'(strobe_out), 128'hFFFF);
    rdy_in = 1'b1;
    px(15, 3, 0, 16'h300F, 1'b0);
    for (int x = 16; x < 24; x++)
      px(x, 3, 0, 16'h3000 + 16'(x), 1'b0);
    idle(4);
    check("t3_drained", 128'(busy_out), 0);

    // second framebuffer
    px(0, 1, 1, 16'h4444, 1'b0);
    flush_pulse();
    wait_out("t4_seen");
    check("t4_addr", 128'(addr_out), 7240);
    check("t4_strobe", 128'(strobe_out), 128'h0003);
    idle(3);

    // masked pixel and empty flush
    for (int x = 0; x < 8; x++)
      px(x, 4, 0, 16'h5000 + 16'(x), x == 2);
    px(100, 4, 0, 16'h5100, 1'b0);
    check("t5_valid", 128'(valid_out), 1);
    check("t5_addr", 128'(addr_out), 160);
    check("t5_strobe", 128'(strobe_out), 128'hFFCF);
    flush_pulse();
    idle(3);
    flush_pulse();
    for (int n = 0; n < 4; n++) begin
      check("t5_empty_flush", 128'(valid_out), 0);
      idle(1);
    end

    // same-slot overwrite
    px(5, 2, 0, 16'hAAAA, 1'b0);
    px(5, 2, 0, 16'h5555, 1'b0);
    flush_pulse();
    wait_out("t6_seen");
    check("t6_addr", 128'(addr_out), 80);
    check("t6_slot5", 128'(data_out[80 +: 16]), 128'h5555);
    check("t6_strobe", 128'(strobe_out), 128'h0C00);
    idle(3);

    // reset with a held write and a partial word
    rdy_in = 1'b0;
    for (int x = 0; x < 3; x++)
      px(x, 5, 0, 16'h6000 + 16'(x), 1'b0);
    px(0, 6, 0, 16'h6100, 1'b0);
    px(1, 6, 0, 16'h6101, 1'b0);
    check("t6_pre_valid", 128'(valid_out), 1);
    check("t6_pre_busy", 128'(busy_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", 128'(valid_out), 0);
    check("t6_async_busy", 128'(busy_out), 0);
    idle(2);
    rst_n = 1'b1;
    rdy_in = 1'b1;
    idle(25);
    check("t6_no_write", 128'(valid_out), 0);
    check("t6_end_busy", 128'(busy_out), 0);
    check("model_drained", 128'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
